// File: rtl/axis_arb_pkg.sv
// Shared types, widths and the round-robin search helper for the packet arbiter.
package axis_arb_pkg;
   typedef enum logic {IDLE = 1'b0, PKT = 1'b1} arb_state_e;

   localparam int AXIS_DATA_W = 32;
   localparam int AXIS_USER_W = 1;
   localparam int MAX_PORTS   = 8;

   // Wrapping mod 8 matches wrapping mod NUM_PORTS because unused request bits are zero.
   function automatic logic [2:0] next_rr(input logic [MAX_PORTS-1:0] req, input logic [2:0] ptr);
      logic [2:0] port;
      logic [2:0] idx;
      logic       found;
      port  = ptr;
      found = 1'b0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         idx = ptr + 3'(i);
         if (!found && req[idx]) begin
            port  = idx;
            found = 1'b1;
         end
      end
      return port;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_oh_o,
   output logic [$clog2(N)-1:0] gnt_idx_o
);
   localparam int IDX_W = $clog2(N);

   logic [2:0] sel;

   always_comb begin
      sel       = next_rr(MAX_PORTS'(req_i), 3'(ptr_i));
      gnt_idx_o = IDX_W'(sel);
      gnt_oh_o  = '0;
      gnt_oh_o[gnt_idx_o] = |req_i;
   end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin AXI4-Stream arbiter: grant locked per packet, registered
// output stage, saturating beat counter and sticky oversize flag.
module axis_pkt_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_PORTS     = 4,
   parameter int DATA_W        = AXIS_DATA_W,
   parameter int USER_W        = AXIS_USER_W,
   parameter int MAX_PKT_BEATS = 256
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
   output logic [NUM_PORTS-1:0]         s_axis_tready,
   input  logic [NUM_PORTS*DATA_W-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS*USER_W-1:0]  s_axis_tuser,
   input  logic [NUM_PORTS-1:0]         s_axis_tlast,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [DATA_W-1:0]            m_axis_tdata,
   output logic [USER_W-1:0]            m_axis_tuser,
   output logic                         m_axis_tlast,
   output logic [$clog2(NUM_PORTS)-1:0] grant_id,
   output logic                         busy,
   output logic                         err_oversize,
   input  logic                         err_clr
);
   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PKT_BEATS);
   localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(MAX_PKT_BEATS - 1);

   arb_state_e           state_q;
   logic [IDX_W-1:0]     rr_ptr_q, grant_q, arb_idx;
   logic [NUM_PORTS-1:0] arb_oh;
   logic [CNT_W-1:0]     beat_cnt_q;
   logic                 m_valid_q, m_last_q, err_q;
   logic [DATA_W-1:0]    m_data_q, sel_data;
   logic [USER_W-1:0]    m_user_q, sel_user;
   logic                 out_rdy, sel_valid, sel_last, accept, set_err;

   rr_arbiter #(.N(NUM_PORTS)) u_rr (
      .req_i     (s_axis_tvalid),
      .ptr_i     (rr_ptr_q),
      .gnt_oh_o  (arb_oh),
      .gnt_idx_o (arb_idx)
   );

   // Handshake: a beat moves on any edge where valid and ready are both high. Upstream,
   // only the granted port sees ready, and only while the output register is empty or
   // draining this cycle; downstream, m_axis_tvalid stays high and the beat stable until taken.
   always_comb begin
      sel_valid = s_axis_tvalid[grant_q];
      sel_last  = s_axis_tlast[grant_q];
      sel_data  = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
      sel_user  = s_axis_tuser[int'(grant_q)*USER_W +: USER_W];
      out_rdy   = ~m_valid_q | m_axis_tready;
      accept    = (state_q == PKT) & sel_valid & out_rdy;
      // A non-last beat that brings the count to the limit means the packet is too long.
      set_err   = accept & ~sel_last & (beat_cnt_q >= CNT_NEAR);
      s_axis_tready = '0;
      if (state_q == PKT) s_axis_tready[grant_q] = out_rdy;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_user_q   <= '0;
         m_last_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= sel_data;
            m_user_q  <= sel_user;
            m_last_q  <= sel_last;
            if (beat_cnt_q != CNT_MAX) beat_cnt_q <= beat_cnt_q + 1'b1;
         end else if (m_axis_tready) begin
            m_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (|arb_oh) begin
                  grant_q <= arb_idx;
                  state_q <= PKT;
               end
            end
            PKT: begin
               if (accept && sel_last) begin
                  state_q    <= IDLE;
                  rr_ptr_q   <= (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                  beat_cnt_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (set_err)      err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tuser  = m_user_q;
   assign m_axis_tlast  = m_last_q;
   assign grant_id      = grant_q;
   assign busy          = (state_q == PKT);
   assign err_oversize  = err_q;
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-port source queues, a packet-level reference
// model compared every cycle, and literal expectations on the observed output stream.
module tb_axis_pkt_arbiter;
   localparam int NP   = 4;
   localparam int DW   = 32;
   localparam int MAXB = 256;

   typedef struct packed {
      logic [31:0] d;
      logic        u;
      logic        l;
   } beat_t;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [NP-1:0]   s_axis_tvalid = '0;
   logic [NP-1:0]   s_axis_tready;
   logic [NP*DW-1:0] s_axis_tdata = '0;
   logic [NP-1:0]   s_axis_tuser = '0;
   logic [NP-1:0]   s_axis_tlast = '0;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b1;
   logic [DW-1:0]   m_axis_tdata;
   logic [0:0]      m_axis_tuser;
   logic            m_axis_tlast;
   logic [1:0]      grant_id;
   logic            busy;
   logic            err_oversize;
   logic            err_clr = 1'b0;

   always #5 clk = ~clk;

   axis_pkt_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .USER_W(1), .MAX_PKT_BEATS(MAXB)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .grant_id      (grant_id),
      .busy          (busy),
      .err_oversize  (err_oversize),
      .err_clr       (err_clr)
   );

   int    n_pass = 0;
   int    n_tot  = 0;
   int    cyc    = 0;
   beat_t src_q[NP][$];
   bit    rdy_pat[$];
   bit    clr_req = 1'b0;
   beat_t log_q[$];
   int    log_cyc[$];

   // Reference model: owner is the port holding the packet, -1 when arbitrating.
   int    md_owner, md_ptr, md_gid, md_beats;
   bit    md_vld, md_err;
   beat_t md_out;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      md_owner = -1; md_ptr = 0; md_gid = 0; md_beats = 0;
      md_vld = 1'b0; md_err = 1'b0; md_out = '0;
   endtask

   task automatic model_step();
      int    n_owner, n_ptr, n_gid, n_beats, k;
      bit    n_vld, set_e;
      beat_t n_out;
      if (!rstn) begin
         model_reset();
         return;
      end
      n_owner = md_owner; n_ptr = md_ptr; n_gid = md_gid; n_beats = md_beats;
      n_vld = md_vld; n_out = md_out; set_e = 1'b0;
      if (md_owner < 0) begin
         if (m_axis_tready) n_vld = 1'b0;
         for (int i = NP - 1; i >= 0; i--) begin
            if (s_axis_tvalid[(md_ptr + i) % NP]) begin
               n_owner = (md_ptr + i) % NP;
               n_gid   = n_owner;
            end
         end
      end else if (s_axis_tvalid[md_owner] && (!md_vld || m_axis_tready)) begin
         n_out = '{d: s_axis_tdata[md_owner*DW +: DW], u: s_axis_tuser[md_owner],
                   l: s_axis_tlast[md_owner]};
         n_vld = 1'b1;
         k = md_beats + 1;
         set_e = !n_out.l && (k >= MAXB);
         n_beats = (k > MAXB) ? MAXB : k;
         if (n_out.l) begin
            n_owner = -1;
            n_ptr   = (md_owner + 1) % NP;
            n_beats = 0;
         end
      end else if (m_axis_tready) begin
         n_vld = 1'b0;
      end
      if (set_e)        md_err = 1'b1;
      else if (err_clr) md_err = 1'b0;
      md_owner = n_owner; md_ptr = n_ptr; md_gid = n_gid; md_beats = n_beats;
      md_vld = n_vld; md_out = n_out;
   endtask

   task automatic cycle();
      logic [NP-1:0] exp_rdy;
      @(negedge clk);
      cyc++;
      chk("m_tvalid", m_axis_tvalid, md_vld);
      chk("m_tdata", m_axis_tdata, md_out.d);
      chk("m_tuser", m_axis_tuser, md_out.u);
      chk("m_tlast", m_axis_tlast, md_out.l);
      chk("grant_id", grant_id, md_gid);
      chk("busy", busy, md_owner >= 0);
      chk("err_oversize", err_oversize, md_err);
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() != 0) begin
            s_axis_tvalid[p] = 1'b1;
            s_axis_tdata[p*DW +: DW] = src_q[p][0].d;
            s_axis_tuser[p] = src_q[p][0].u;
            s_axis_tlast[p] = src_q[p][0].l;
         end else begin
            s_axis_tvalid[p] = 1'b0;
            s_axis_tdata[p*DW +: DW] = '0;
            s_axis_tuser[p] = 1'b0;
            s_axis_tlast[p] = 1'b0;
         end
      end
      m_axis_tready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
      err_clr = clr_req;
      #1;
      exp_rdy = '0;
      if (md_owner >= 0) exp_rdy[md_owner] = !md_vld || m_axis_tready;
      chk("s_tready", s_axis_tready, exp_rdy);
      if (m_axis_tvalid && m_axis_tready) begin
         log_q.push_back('{d: m_axis_tdata, u: m_axis_tuser[0], l: m_axis_tlast});
         log_cyc.push_back(cyc);
      end
      model_step();
      for (int p = 0; p < NP; p++)
         if (s_axis_tvalid[p] && s_axis_tready[p]) void'(src_q[p].pop_front());
   endtask

   task automatic push_beat(input int p, input logic [31:0] d, input bit u, input bit l);
      src_q[p].push_back('{d: d, u: u, l: l});
   endtask

   task automatic push_pkt(input int p, input int n, input logic [31:0] base);
      for (int b = 0; b < n; b++) push_beat(p, base + 32'(b), b == 0, b == n - 1);
   endtask

   function automatic bit pending();
      bit any = md_owner >= 0 || md_vld;
      for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) any = 1'b1;
      return any;
   endfunction

   task automatic run_idle(input string tag, input int budget);
      int n = 0;
      while (pending() && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_timeout"}, n < budget, 1'b1);
      cycle();
   endtask

   function automatic int tag_of(input int i);
      return int'(log_q[i].d[31:24]) - 'hA0;
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      int t_start, n;
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      int exp_t5[6]  = '{2, 2, 2, 2, 3, 3};
      logic [31:0] b32;
      model_reset();

      // Long reset: everything zero.
      repeat (40) cycle();
      chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_m_tdata", m_axis_tdata, 32'h0);
      chk("rst_m_tlast", m_axis_tlast, 1'b0);
      chk("rst_s_tready", s_axis_tready, 4'h0);
      chk("rst_grant_busy_err", {grant_id, busy, err_oversize}, 4'h0);
      rstn = 1'b1;
      cycle();

      // Single-port 8-beat packet.
      log_q.delete(); log_cyc.delete();
      for (int b = 0; b < 8; b++)
         push_beat(0, (b == 7) ? 32'hFF23_4567 : 32'h6745_2301, b == 0, b == 7);
      t_start = cyc + 1;
      run_idle("t2", 100);
      chk("t2_count", log_q.size(), 8);
      chk("t2_first_latency", log_cyc[0] - t_start, 2);
      chk("t2_beat0", {log_q[0].d, log_q[0].u, log_q[0].l}, {32'h6745_2301, 2'b10});
      chk("t2_beat1_user", log_q[1].u, 1'b0);
      chk("t2_beat6", {log_q[6].d, log_q[6].l}, {32'h6745_2301, 1'b0});
      chk("t2_last", {log_q[7].d, log_q[7].u, log_q[7].l}, {32'hFF23_4567, 2'b01});
      chk("t2_throughput", log_cyc[7] - log_cyc[0], 7);

      // Asynchronous reset in the middle of a packet.
      push_pkt(1, 6, 32'hB100_0000);
      repeat (4) cycle();
      @(negedge clk);
      chk("mid_pre_valid", m_axis_tvalid, 1'b1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_async_valid", m_axis_tvalid, 1'b0);
      chk("mid_async_busy", busy, 1'b0);
      model_reset();
      for (int p = 0; p < NP; p++) src_q[p].delete();
      repeat (3) cycle();
      rstn = 1'b1;
      repeat (3) cycle();

      // All ports requesting: rotation 0,1,2,3,0 with one bubble between packets.
      log_q.delete(); log_cyc.delete();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NP; p++)
            if (k == 0 || p == 0) begin
               b32 = 32'hA000_0000 | (32'(p) << 24) | (32'(k) << 16);
               push_pkt(p, 2, b32);
            end
      run_idle("t3", 200);
      chk("t3_count", log_q.size(), 10);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_order%0d", i), tag_of(2 * i), exp_ord[i]);
         chk($sformatf("t3_last%0d", i), log_q[2 * i + 1].l, 1'b1);
         if (i > 0) chk($sformatf("t3_bubble%0d", i), log_cyc[2 * i] - log_cyc[2 * i - 1], 2);
      end

      // Port 1 with a downstream stall pattern.
      log_q.delete(); log_cyc.delete();
      push_pkt(1, 4, 32'hB000_0000);
      rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      run_idle("t4", 100);
      chk("t4_count", log_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t4_data%0d", i), log_q[i].d, 32'hB000_0000 + 32'(i));
      chk("t4_stall_gap", log_cyc[1] - log_cyc[0], 3);

      // Port 2 gap while port 3 waits.
      log_q.delete(); log_cyc.delete();
      push_beat(2, 32'hA200_0000, 1'b1, 1'b0);
      push_beat(2, 32'hA200_0001, 1'b0, 1'b0);
      push_pkt(3, 2, 32'hA300_0000);
      n = 0;
      while (src_q[2].size() != 0 && n < 50) begin
         cycle();
         n++;
      end
      chk("t5_drain_timeout", n < 50, 1'b1);
      repeat (3) cycle();
      chk("t5_gap_grant", {busy, grant_id}, {1'b1, 2'd2});
      push_beat(2, 32'hA200_0002, 1'b0, 1'b0);
      push_beat(2, 32'hA200_0003, 1'b0, 1'b1);
      run_idle("t5", 100);
      chk("t5_count", log_q.size(), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t5_order%0d", i), tag_of(i), exp_t5[i]);

      // Oversize: exactly MAXB beats is legal, MAXB+1 sets the sticky flag.
      push_pkt(0, MAXB, 32'hA000_0000);
      run_idle("t6a", 1000);
      chk("t6_max_ok", err_oversize, 1'b0);
      push_pkt(0, MAXB + 1, 32'hA000_1000);
      run_idle("t6b", 1000);
      chk("t6_oversize", err_oversize, 1'b1);
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      cycle();
      chk("t6_cleared", err_oversize, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
